// File: rtl/alu_cmd_issuer.sv
// Command issuer for the ALU: buffers packets in a FIFO and sequences operands, CE and RES_VALID.
// Optional ALU_ISSUER_STATS_EN adds saturating ISSUE_CNT / SPLIT_CNT counters.
module alu_cmd_issuer #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned LATENCY     = 1,
   parameter int unsigned MUL_LATENCY = 2,
   parameter int unsigned SPLIT_GAP   = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   input  logic                     IN_MODE,
   input  logic [3:0]               IN_CMD,
   input  logic [WIDTH-1:0]         IN_OPA,
   input  logic [WIDTH-1:0]         IN_OPB,
   input  logic                     IN_CIN,
   input  logic                     IN_SPLIT,
   output logic [1:0]               INP_VALID,
   output logic                     MODE,
   output logic [3:0]               CMD,
   output logic                     CE,
   output logic [WIDTH-1:0]         OPA,
   output logic [WIDTH-1:0]         OPB,
   output logic                     CIN,
   output logic                     RES_VALID,
   output logic                     BUSY,
   output logic [$clog2(DEPTH):0]   FIFO_COUNT
`ifdef ALU_ISSUER_STATS_EN
   ,
   output logic [15:0]              ISSUE_CNT,
   output logic [15:0]              SPLIT_CNT
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = 2 * WIDTH + 7;
   localparam int unsigned CW = 8;

   typedef enum logic [2:0] {StIdle, StIssue, StIssueA, StGap, StIssueB, StWait} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push, pop;
   logic [PW-1:0]    pkt_in;
   logic             hd_mode, hd_cin, hd_split;
   logic [3:0]       hd_cmd;
   logic [WIDTH-1:0] hd_opa, hd_opb;
   logic             mode_q, mode_d, cin_q, cin_d, split_q, split_d;
   logic [3:0]       cmd_q, cmd_d;
   logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, pend_opb_q, pend_opb_d;
   logic [CW-1:0]    lat_sel;

   assign pkt_in   = {IN_MODE, IN_CMD, IN_OPA, IN_OPB, IN_CIN, IN_SPLIT};
   assign {hd_mode, hd_cmd, hd_opa, hd_opb, hd_cin, hd_split} = mem_q[rd_ptr_q];
   assign IN_READY = !RST && (count_q < (AW + 1)'(DEPTH));
   assign push     = IN_VALID && IN_READY;

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= pkt_in;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (!push && pop) count_q <= count_q - 1'b1;
      end
   end

   // Multiplies (MODE=1, CMD 9/10) take the longer ALU latency.
   assign lat_sel = (mode_q && (cmd_q == 4'd9 || cmd_q == 4'd10)) ? CW'(MUL_LATENCY)
                                                                  : CW'(LATENCY);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pop        = 1'b0;
      mode_d     = mode_q;
      cmd_d      = cmd_q;
      cin_d      = cin_q;
      split_d    = split_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      pend_opb_d = pend_opb_q;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               pop        = 1'b1;
               mode_d     = hd_mode;
               cmd_d      = hd_cmd;
               cin_d      = hd_cin;
               split_d    = hd_split;
               opa_d      = hd_opa;
               pend_opb_d = hd_opb;
               opb_d      = hd_split ? '0 : hd_opb;
               state_d    = hd_split ? StIssueA : StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
            cnt_d   = lat_sel;
         end
         StIssueA: begin
            if (SPLIT_GAP > 0) begin
               state_d = StGap;
               cnt_d   = CW'(SPLIT_GAP);
            end else begin
               state_d = StIssueB;
               opb_d   = pend_opb_q;
            end
         end
         StGap: begin
            if (cnt_q <= CW'(1)) begin
               state_d = StIssueB;
               opb_d   = pend_opb_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StIssueB: begin
            state_d = StWait;
            cnt_d   = lat_sel;
         end
         StWait: begin
            if (cnt_q <= CW'(1)) state_d = StIdle;
            else                 cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      INP_VALID = 2'b00;
      unique case (state_q)
         StIssue:  INP_VALID = 2'b11;
         StIssueA: INP_VALID = 2'b01;
         StIssueB: INP_VALID = 2'b10;
         default:  INP_VALID = 2'b00;
      endcase
   end

   assign BUSY      = (state_q != StIdle);
   assign CE        = BUSY;
   assign RES_VALID = (state_q == StWait) && (cnt_q <= CW'(1));
   assign MODE      = mode_q;
   assign CMD       = cmd_q;
   assign CIN       = cin_q;
   assign OPA       = opa_q;
   assign OPB       = opb_q;
   assign FIFO_COUNT = count_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         mode_q     <= 1'b0;
         cmd_q      <= '0;
         cin_q      <= 1'b0;
         split_q    <= 1'b0;
         opa_q      <= '0;
         opb_q      <= '0;
         pend_opb_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         cmd_q      <= cmd_d;
         cin_q      <= cin_d;
         split_q    <= split_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         pend_opb_q <= pend_opb_d;
      end
   end

`ifdef ALU_ISSUER_STATS_EN
   logic [15:0] issue_cnt_q, split_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         issue_cnt_q <= '0;
         split_cnt_q <= '0;
      end else if (RES_VALID) begin
         if (issue_cnt_q != 16'hFFFF) issue_cnt_q <= issue_cnt_q + 1'b1;
         if (split_q && split_cnt_q != 16'hFFFF) split_cnt_q <= split_cnt_q + 1'b1;
      end
   end

   assign ISSUE_CNT = issue_cnt_q;
   assign SPLIT_CNT = split_cnt_q;
`endif

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Upstream stage of the alu block.
- Accepts complete command packets over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU operand/control inputs one command at a time. A packet flagged "split" presents OPA and OPB in separate cycles using INP_VALID 01 then 10.
- Waits the ALU's latency for each command and pulses RES_VALID in the cycle the ALU outputs are valid, so a downstream capture stage knows when to sample.

Parameters:
- WIDTH, 8, operand width of OPA/OPB and IN_OPA/IN_OPB.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- LATENCY, 1, cycles from final operand presentation to valid ALU result, for non-multiply commands.
- MUL_LATENCY, 2, same, for MODE=1 with CMD=9 or CMD=10.
- SPLIT_GAP, 2, idle cycles between the OPA-only and OPB-only presentations of a split packet; range 0..15.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- IN_VALID  in  1  packet valid.
- IN_READY  out  1  FIFO not full.
- IN_MODE  in  1  packet mode.
- IN_CMD  in  4  packet command.
- IN_OPA  in  WIDTH  packet operand A.
- IN_OPB  in  WIDTH  packet operand B.
- IN_CIN  in  1  packet carry-in.
- IN_SPLIT  in  1  present operands in separate cycles.
- INP_VALID  out  2  to ALU.
- MODE  out  1  to ALU.
- CMD  out  4  to ALU.
- CE  out  1  to ALU.
- OPA  out  WIDTH  to ALU.
- OPB  out  WIDTH  to ALU.
- CIN  out  1  to ALU.
- RES_VALID  out  1  one-cycle pulse; ALU outputs valid this cycle.
- BUSY  out  1  FSM not in IDLE.
- FIFO_COUNT  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Clocking and reset:
  - Single clock CLK. Reset RST is synchronous, active-high.
  - While RST=1 at a rising edge: FIFO is emptied and FSM goes to IDLE.
  - Reset values: INP_VALID=00, MODE=0, CMD=0, CE=0, OPA=0, OPB=0, CIN=0, RES_VALID=0, BUSY=0, FIFO_COUNT=0. IN_READY=0 during reset, 1 in the cycle after.
  - Reset mid-command aborts the command with no RES_VALID pulse.
- Handshake:
  - A push occurs on a rising edge with IN_VALID=1, IN_READY=1.
  - IN_READY = (FIFO_COUNT<DEPTH), combinational from registered count.
  - Push and pop in the same cycle leave the count unchanged and are legal when full, but IN_READY stays 0 when full.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, ISSUE_A, GAP, ISSUE_B, WAIT.
  - IDLE:
    - If FIFO is non-empty, pop the head.
    - If the packet's split bit is 0, go to ISSUE; if it is 1, go to ISSUE_A.
    - Outputs: INP_VALID=00, CE=0. Operand outputs hold their last values.
  - ISSUE, 1 cycle:
    - INP_VALID=11, CE=1, all fields driven from the popped packet.
    - Next state: WAIT, with counter = (MODE=1 && CMD∈{9,10}) ? MUL_LATENCY : LATENCY.
  - ISSUE_A, 1 cycle:
    - INP_VALID=01, OPA=pkt.OPA, OPB=0, CE=1.
    - Next state: GAP if SPLIT_GAP>0, else ISSUE_B.
  - GAP, SPLIT_GAP cycles: INP_VALID=00, CE=1, and all other outputs hold.
  - ISSUE_B, 1 cycle:
    - INP_VALID=10, OPA retained, OPB=pkt.OPB, CE=1.
    - Next state: WAIT, with the latency loaded as in ISSUE.
  - WAIT:
    - INP_VALID=00, CE=1. The counter decrements each cycle.
    - When the counter reaches 1, RES_VALID=1 for that cycle and the next state is IDLE.
    - RES_VALID therefore occurs exactly L cycles after the final issue cycle, where L is the selected latency.
- Issue spacing:
  - The earliest next issue is the cycle after the RES_VALID pulse.
  - There is no back-to-back overlap: one command is in flight at a time.
- BUSY=1 in every state except IDLE.
- MODE, CMD and CIN are held constant from ISSUE/ISSUE_A through WAIT.
- A push during any state is accepted if not full.
- If the FIFO is empty in IDLE, the FSM stays in IDLE.

Optional Feature:
- Macro: ALU_ISSUER_STATS_EN.
- When defined:
  - Adds output ISSUE_CNT[15:0] and output SPLIT_CNT[15:0].
  - Both are 0 on reset.
  - ISSUE_CNT increments on each RES_VALID pulse.
  - SPLIT_CNT increments on each RES_VALID pulse that ends a split packet.
  - Both saturate at 16'hFFFF.
- When undefined: these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
- Reset then push {MODE=1,CMD=0,OPA=8'h12,OPB=8'h34,CIN=0,SPLIT=0} -> next cycle ISSUE with INP_VALID=11, OPA=12, OPB=34, CE=1. RES_VALID exactly 1 cycle later; BUSY drops after it.
- Push {MODE=1,CMD=9,OPA=3,OPB=4,SPLIT=0} -> RES_VALID exactly 2 cycles after the issue cycle (MUL_LATENCY).
- Push {MODE=0,CMD=1,OPA=8'hF0,OPB=8'h0F,SPLIT=1}, SPLIT_GAP=2 -> cycle sequence INP_VALID 01, 00, 00, 10, then 00 with RES_VALID one cycle after the 10 cycle. OPA stays F0 throughout.
- Push 6 packets back-to-back, DEPTH=4, FSM busy -> IN_READY=0 when FIFO_COUNT=4; stall released on pop. All 6 issue in push order; exactly 6 RES_VALID pulses.
- Assert RST for 1 cycle during WAIT of a multiply -> no RES_VALID, all outputs at reset values next cycle, FIFO_COUNT=0.
- With ALU_ISSUER_STATS_EN: 3 non-split + 2 split packets -> ISSUE_CNT=5, SPLIT_CNT=2 after the last RES_VALID.
